// File: rtl/ball_controller_if.sv
// Signal bundle between the Pong ball sequencer, the paddle/input logic and the ball sprite.
interface ball_controller_if;
    logic       start;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] paddle_left_y;
    logic [9:0] paddle_right_y;
    logic       bounce_trigger;
    logic       bounce_direction;
    logic       ball_reset_n;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       game_over;

    // Game-side view: drives start and positions, observes ball control and scores
    modport master (
        output start, ball_x, ball_y, paddle_left_y, paddle_right_y,
        input  bounce_trigger, bounce_direction, ball_reset_n,
        input  score_left, score_right, game_over
    );

    // Sequencer view
    modport slave (
        input  start, ball_x, ball_y, paddle_left_y, paddle_right_y,
        output bounce_trigger, bounce_direction, ball_reset_n,
        output score_left, score_right, game_over
    );
endinterface

// File: rtl/ball_controller.sv
// Pong ball sequencer: serve, wall/paddle bounces, misses, scoring and game over.
module ball_controller #(
    parameter int unsigned TOP_Y       = 0,
    parameter int unsigned BOTTOM_Y    = 480,
    parameter int unsigned BALL_W      = 30,
    parameter int unsigned BALL_H      = 30,
    parameter int unsigned PADDLE_LX   = 20,
    parameter int unsigned PADDLE_RX   = 610,
    parameter int unsigned PADDLE_W    = 10,
    parameter int unsigned PADDLE_H    = 80,
    parameter int unsigned MISS_L      = 2,
    parameter int unsigned MISS_R      = 638,
    parameter int unsigned RESET_TICKS = 4,
    parameter int unsigned SERVE_DELAY = 60,
    parameter int unsigned WIN_SCORE   = 9
) (
    input  logic               tick,
    input  logic               reset,
    ball_controller_if.slave   bus
);
    // Collision constants widened to 11 bits so position sums never wrap
    localparam logic [10:0] TOP_Y_W    = 11'(TOP_Y);
    localparam logic [10:0] BOTTOM_Y_W = 11'(BOTTOM_Y);
    localparam logic [10:0] BALL_W_W   = 11'(BALL_W);
    localparam logic [10:0] BALL_H_W   = 11'(BALL_H);
    localparam logic [10:0] PAD_L_EDGE = 11'(PADDLE_LX + PADDLE_W);
    localparam logic [10:0] PAD_R_EDGE = 11'(PADDLE_RX);
    localparam logic [10:0] PADDLE_H_W = 11'(PADDLE_H);
    localparam logic [10:0] MISS_L_W   = 11'(MISS_L);
    localparam logic [10:0] MISS_R_W   = 11'(MISS_R);
    localparam logic [7:0]  SERVE_LAST = 8'(SERVE_DELAY - 1);
    localparam logic [7:0]  RESET_LAST = 8'(RESET_TICKS - 1);
    localparam logic [3:0]  WIN_W      = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SERVE,
        S_HOLD,
        S_PLAYING,
        S_POINT,
        S_GAME_OVER
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       dir_left;
    logic       dir_up;
    logic       serve_right;
    logic       from_bounce;
    logic [9:0] cap_x;
    logic [9:0] cap_y;

    logic       trigger_q;
    logic       direction_q;
    logic       ball_reset_n_q;
    logic [3:0] score_left_q;
    logic [3:0] score_right_q;
    logic       game_over_q;

    logic [10:0] bx, by, bx_far, by_far, pl_y, pr_y;
    logic        overlap_l, overlap_r;
    logic        miss_l, miss_r, pad_hit, wall_hit, moved, win;

    assign bx     = 11'(bus.ball_x);
    assign by     = 11'(bus.ball_y);
    assign pl_y   = 11'(bus.paddle_left_y);
    assign pr_y   = 11'(bus.paddle_right_y);
    assign bx_far = bx + BALL_W_W;
    assign by_far = by + BALL_H_W;

    assign overlap_l = (by_far > pl_y) && (by < pl_y + PADDLE_H_W);
    assign overlap_r = (by_far > pr_y) && (by < pr_y + PADDLE_H_W);

    assign miss_l   = dir_left && (bx <= MISS_L_W);
    assign miss_r   = !dir_left && (bx_far >= MISS_R_W);
    assign pad_hit  = dir_left ? ((bx <= PAD_L_EDGE) && overlap_l)
                               : ((bx_far >= PAD_R_EDGE) && overlap_r);
    assign wall_hit = dir_up ? (by <= TOP_Y_W) : (by_far >= BOTTOM_Y_W);
    assign moved    = (bus.ball_x != cap_x) || (bus.ball_y != cap_y);
    assign win      = (score_left_q == WIN_W) || (score_right_q == WIN_W);

    assign bus.bounce_trigger   = trigger_q;
    assign bus.bounce_direction = direction_q;
    assign bus.ball_reset_n     = ball_reset_n_q;
    assign bus.score_left       = score_left_q;
    assign bus.score_right      = score_right_q;
    assign bus.game_over        = game_over_q;

    // Game sequencer with registered ball-control and score outputs
    always_ff @(posedge tick or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= 8'd0;
            dir_left       <= 1'b0;
            dir_up         <= 1'b0;
            serve_right    <= 1'b0;
            from_bounce    <= 1'b0;
            cap_x          <= 10'd0;
            cap_y          <= 10'd0;
            trigger_q      <= 1'b0;
            direction_q    <= 1'b0;
            ball_reset_n_q <= 1'b0;
            score_left_q   <= 4'd0;
            score_right_q  <= 4'd0;
            game_over_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_GAME_OVER: begin
                    if (bus.start) begin
                        state          <= S_WAIT;
                        cnt            <= 8'd0;
                        score_left_q   <= 4'd0;
                        score_right_q  <= 4'd0;
                        game_over_q    <= 1'b0;
                        ball_reset_n_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt == SERVE_LAST) begin
                        cnt         <= 8'd0;
                        state       <= S_SERVE;
                        trigger_q   <= 1'b1;
                        direction_q <= serve_right;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_SERVE: begin
                    // Ball maps HORIZONTAL to left-down and VERTICAL to right-down
                    dir_left    <= !serve_right;
                    dir_up      <= 1'b0;
                    from_bounce <= 1'b0;
                    cap_x       <= bus.ball_x;
                    cap_y       <= bus.ball_y;
                    state       <= S_HOLD;
                end
                S_HOLD: begin
                    if (moved) begin
                        trigger_q <= 1'b0;
                        state     <= S_PLAYING;
                        if (from_bounce) begin
                            if (direction_q) dir_left <= !dir_left;
                            else             dir_up   <= !dir_up;
                        end
                    end
                end
                S_PLAYING: begin
                    if (miss_l || miss_r) begin
                        if (miss_l) score_right_q <= score_right_q + 4'd1;
                        else        score_left_q  <= score_left_q + 4'd1;
                        // Next serve heads toward whoever conceded
                        serve_right    <= miss_r;
                        ball_reset_n_q <= 1'b0;
                        cnt            <= 8'd0;
                        state          <= S_POINT;
                    end else if (pad_hit || wall_hit) begin
                        trigger_q   <= 1'b1;
                        direction_q <= pad_hit;
                        from_bounce <= 1'b1;
                        cap_x       <= bus.ball_x;
                        cap_y       <= bus.ball_y;
                        state       <= S_HOLD;
                    end
                end
                S_POINT: begin
                    if (cnt == RESET_LAST) begin
                        cnt <= 8'd0;
                        if (win) begin
                            state       <= S_GAME_OVER;
                            game_over_q <= 1'b1;
                        end else begin
                            state          <= S_WAIT;
                            ball_reset_n_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ball_controller.sv
// Self-checking bench for ball_controller: directed game script plus randomized play.
module tb_ball_controller;
    localparam int TOP_Y = 0, BOTTOM_Y = 480, BALL_W = 30, BALL_H = 30;
    localparam int PADDLE_LX = 20, PADDLE_RX = 610, PADDLE_W = 10, PADDLE_H = 80;
    localparam int MISS_L = 2, MISS_R = 638;
    localparam int RESET_TICKS = 4, SERVE_DELAY = 60, WIN_SCORE = 9;

    localparam int M_IDLE = 0, M_WAIT = 1, M_SERVE = 2, M_HOLD = 3;
    localparam int M_PLAY = 4, M_POINT = 5, M_OVER = 6;

    logic tick = 1'b0;
    logic reset;
    ball_controller_if bus();

    ball_controller #(
        .TOP_Y(TOP_Y), .BOTTOM_Y(BOTTOM_Y), .BALL_W(BALL_W), .BALL_H(BALL_H),
        .PADDLE_LX(PADDLE_LX), .PADDLE_RX(PADDLE_RX), .PADDLE_W(PADDLE_W),
        .PADDLE_H(PADDLE_H), .MISS_L(MISS_L), .MISS_R(MISS_R),
        .RESET_TICKS(RESET_TICKS), .SERVE_DELAY(SERVE_DELAY), .WIN_SCORE(WIN_SCORE)
    ) dut (
        .tick (tick),
        .reset(reset),
        .bus  (bus)
    );

    always #5 tick = ~tick;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: game phase, deadlines as absolute tick numbers
    int cyc = 0;
    int m_mode, m_due;
    int m_trig, m_dir, m_rstn, m_sl, m_sr, m_over;
    int m_left, m_up, m_serve_right, m_after_bounce, m_cap_x, m_cap_y;

    int unsigned x_edges[16] = '{0, 1, 2, 3, 29, 30, 31, 578, 579, 580, 581, 607, 608, 609, 1000, 1023};
    int unsigned y_edges[8]  = '{0, 1, 2, 448, 449, 450, 451, 1010};

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_due = 0;
        m_trig = 0; m_dir = 0; m_rstn = 0; m_sl = 0; m_sr = 0; m_over = 0;
        m_left = 0; m_up = 0; m_serve_right = 0; m_after_bounce = 0;
        m_cap_x = 0; m_cap_y = 0;
    endtask

    task automatic begin_point(input int right_scored);
        if (right_scored != 0) m_sr = m_sr + 1;
        else                   m_sl = m_sl + 1;
        m_serve_right = (right_scored != 0) ? 0 : 1;
        m_rstn = 0;
        m_due  = cyc + RESET_TICKS;
        m_mode = M_POINT;
    endtask

    task automatic begin_bounce(input int vertical, input int x, input int y);
        m_trig = 1; m_dir = vertical; m_after_bounce = 1;
        m_cap_x = x; m_cap_y = y;
        m_mode = M_HOLD;
    endtask

    // One game tick of the reference model, using the inputs present at the edge
    task automatic model_edge();
        int x, y, pl, pr;
        int hit_l, hit_r;
        x = int'(bus.ball_x); y = int'(bus.ball_y);
        pl = int'(bus.paddle_left_y); pr = int'(bus.paddle_right_y);
        cyc++;
        case (m_mode)
            M_IDLE, M_OVER: if (bus.start) begin
                m_sl = 0; m_sr = 0; m_over = 0; m_rstn = 1;
                m_mode = M_WAIT; m_due = cyc + SERVE_DELAY;
            end
            M_WAIT: if (cyc == m_due) begin
                m_mode = M_SERVE; m_trig = 1; m_dir = m_serve_right;
            end
            M_SERVE: begin
                m_left = (m_serve_right != 0) ? 0 : 1; m_up = 0;
                m_after_bounce = 0; m_cap_x = x; m_cap_y = y;
                m_mode = M_HOLD;
            end
            M_HOLD: if (x != m_cap_x || y != m_cap_y) begin
                m_trig = 0; m_mode = M_PLAY;
                if (m_after_bounce != 0) begin
                    if (m_dir != 0) m_left = 1 - m_left;
                    else            m_up   = 1 - m_up;
                end
            end
            M_PLAY: begin
                hit_l = (x <= PADDLE_LX + PADDLE_W) && (y + BALL_H > pl) && (y < pl + PADDLE_H);
                hit_r = (x + BALL_W >= PADDLE_RX) && (y + BALL_H > pr) && (y < pr + PADDLE_H);
                if (m_left != 0 && x <= MISS_L)                 begin_point(1);
                else if (m_left == 0 && x + BALL_W >= MISS_R)   begin_point(0);
                else if (m_left != 0 && hit_l != 0)             begin_bounce(1, x, y);
                else if (m_left == 0 && hit_r != 0)             begin_bounce(1, x, y);
                else if (m_up != 0 && y <= TOP_Y)               begin_bounce(0, x, y);
                else if (m_up == 0 && y + BALL_H >= BOTTOM_Y)   begin_bounce(0, x, y);
            end
            M_POINT: if (cyc == m_due) begin
                if (m_sl == WIN_SCORE || m_sr == WIN_SCORE) begin
                    m_mode = M_OVER; m_over = 1;
                end else begin
                    m_mode = M_WAIT; m_rstn = 1; m_due = cyc + SERVE_DELAY;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic compare_all();
        check("trigger", 32'(bus.bounce_trigger), m_trig);
        if (m_trig != 0) check("direction", 32'(bus.bounce_direction), m_dir);
        check("ball_reset_n", 32'(bus.ball_reset_n), m_rstn);
        check("score_left", 32'(bus.score_left), m_sl);
        check("score_right", 32'(bus.score_right), m_sr);
        check("game_over", 32'(bus.game_over), m_over);
    endtask

    task automatic step();
        @(posedge tick);
        model_edge();
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before the next edge
    task automatic reset_pulse();
        #3 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        #1 reset = 1'b0;
    endtask

    task automatic wait_trigger(input string tag);
        int n;
        n = 0;
        while (bus.bounce_trigger !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        check(tag, 32'(bus.bounce_trigger), 1);
    endtask

    task automatic set_pos(input int x, input int y);
        bus.ball_x = 10'(x);
        bus.ball_y = 10'(y);
    endtask

    // Drive the ball out on the right so the left player scores
    task automatic win_left_point();
        if (m_left != 0) begin
            bus.paddle_left_y = 10'd90;
            set_pos(30, 100); step();
            set_pos(31, 100); step();
        end
        set_pos(620, 200); step();
        repeat (RESET_TICKS) step();
        if (m_over == 0) begin
            wait_trigger("serve_timeout");
            step();
            set_pos(300, 200); step();
        end
    endtask

    function automatic int unsigned pick_x();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 1023);
            1, 2:    return x_edges[$urandom_range(0, 15)];
            default: return $urandom_range(0, 639);
        endcase
    endfunction

    function automatic int unsigned pick_y();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 1023);
            1, 2:    return y_edges[$urandom_range(0, 7)];
            default: return $urandom_range(0, 479);
        endcase
    endfunction

    function automatic int unsigned pick_paddle(input int unsigned by);
        int p;
        if ($urandom_range(0, 1) == 0) return $urandom_range(0, 479);
        p = int'(by) + int'($urandom_range(0, 120)) - 80;
        if (p < 0) p = 0;
        if (p > 1023) p = 1023;
        return 32'(p);
    endfunction

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        set_pos(300, 200);
        bus.paddle_left_y  = 10'd200;
        bus.paddle_right_y = 10'd200;
        model_reset();
        #2;
        compare_all();
        @(negedge tick);
        reset = 1'b0;

        // Start and serve timing
        bus.start = 1'b1; step(); bus.start = 1'b0;
        check("rstn_rise", 32'(bus.ball_reset_n), 1);
        repeat (SERVE_DELAY - 1) step();
        check("pre_serve", 32'(bus.bounce_trigger), 0);
        step();
        check("serve_trig", 32'(bus.bounce_trigger), 1);
        check("serve_dir", 32'(bus.bounce_direction), 0);
        repeat (4) step();
        check("serve_hold", 32'(bus.bounce_trigger), 1);
        set_pos(299, 200); step();
        check("serve_release", 32'(bus.bounce_trigger), 0);

        // Left paddle bounce, then confirm the ball now travels right
        bus.paddle_left_y = 10'd90;
        set_pos(30, 100); step();
        check("lpad_trig", 32'(bus.bounce_trigger), 1);
        check("lpad_dir", 32'(bus.bounce_direction), 1);
        set_pos(31, 100); step();
        check("lpad_release", 32'(bus.bounce_trigger), 0);
        set_pos(2, 100); step();
        check("no_miss_moving_right", 32'(bus.bounce_trigger) + 32'(bus.score_right), 0);

        // Bottom wall to turn upward, then top wall held through a stall
        set_pos(300, 450); step();
        check("bottom_trig", 32'(bus.bounce_trigger), 1);
        set_pos(300, 449); step();
        set_pos(300, 0); step();
        check("top_trig", 32'(bus.bounce_trigger), 1);
        check("top_dir", 32'(bus.bounce_direction), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("top_stall", 32'(bus.bounce_trigger), 1);
        end
        set_pos(300, 1); step();
        check("top_release", 32'(bus.bounce_trigger), 0);

        // Right paddle turns the ball left, then a left miss
        bus.paddle_right_y = 10'd190;
        set_pos(580, 200); step();
        check("rpad_trig", 32'(bus.bounce_trigger), 1);
        set_pos(579, 200); step();
        bus.paddle_left_y = 10'd300;
        set_pos(2, 100); step();
        check("miss_score_right", 32'(bus.score_right), 1);
        for (int i = 0; i < RESET_TICKS - 1; i++) begin
            step();
            check("point_rstn_low", 32'(bus.ball_reset_n), 0);
        end
        step();
        check("point_rstn_high", 32'(bus.ball_reset_n), 1);
        repeat (SERVE_DELAY - 1) step();
        step();
        check("reserve_trig", 32'(bus.bounce_trigger), 1);
        check("reserve_dir", 32'(bus.bounce_direction), 0);
        step();
        set_pos(300, 200); step();

        // Left player runs to the winning score
        for (int i = 0; i < WIN_SCORE; i++) begin
            win_left_point();
            if (i == WIN_SCORE - 2) check("score_left_8", 32'(bus.score_left), 8);
        end
        check("win_score", 32'(bus.score_left), WIN_SCORE);
        check("win_over", 32'(bus.game_over), 1);
        check("win_rstn", 32'(bus.ball_reset_n), 0);
        bus.start = 1'b1; step(); bus.start = 1'b0;
        check("restart_scores", 32'(bus.score_left) + 32'(bus.score_right), 0);
        check("restart_rstn", 32'(bus.ball_reset_n), 1);
        check("restart_over", 32'(bus.game_over), 0);

        // Score a point, then reset while the serve trigger is held
        wait_trigger("serve_timeout");
        step();
        set_pos(300, 200); step();
        set_pos(620, 200); step();
        check("pre_reset_score", 32'(bus.score_left), 1);
        repeat (RESET_TICKS) step();
        wait_trigger("serve_timeout");
        step();
        reset_pulse();
        check("reset_trig", 32'(bus.bounce_trigger), 0);
        check("reset_score", 32'(bus.score_left), 0);
        repeat (3) step();

        // Randomized play against the model
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.ball_x = 10'(pick_x());
                bus.ball_y = 10'(pick_y());
                bus.paddle_left_y  = 10'(pick_paddle(32'(bus.ball_y)));
                bus.paddle_right_y = 10'(pick_paddle(32'(bus.ball_y)));
            end
            bus.start = ($urandom_range(0, 15) == 0);
            step();
            if ($urandom_range(0, 2999) == 0) reset_pulse();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ball_controller.md
# ball_controller

Sequencer for the Pong ball sprite. Watches the ball's on-screen position and both paddle positions, and drives the ball component's `bounce_trigger`, `bounce_direction` and active-LOW `reset`. It handles serve, wall and paddle bounces, misses, scoring and game over. It sits between the paddle/input logic and the ball sprite, runs on the game tick, and replaces ad-hoc collision glue in the top level.

## Interface
Parameters:
- `TOP_Y`, 0: top wall row.
- `BOTTOM_Y`, 480: bottom wall row.
- `BALL_W`, 30: ball sprite width in pixels.
- `BALL_H`, 30: ball sprite height in pixels.
- `PADDLE_LX`, 20: left paddle left edge.
- `PADDLE_RX`, 610: right paddle left edge.
- `PADDLE_W`, 10: paddle width.
- `PADDLE_H`, 80: paddle height.
- `MISS_L`, 2: left miss threshold on `ball_x`.
- `MISS_R`, 638: right miss threshold on `ball_x+BALL_W`.
- `RESET_TICKS`, 4: ticks the ball is held in reset after a point (1..255).
- `SERVE_DELAY`, 60: ticks between ball release and serve (1..255).
- `WIN_SCORE`, 9: score that ends the game (1..15).

Ports:
- `tick` in 1: game tick clock. Only clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: level; starts a game from IDLE or GAME_OVER.
- `ball_x`, `ball_y` in 10 each: ball top-left position.
- `paddle_left_y`, `paddle_right_y` in 10 each: paddle top rows.
- `bounce_trigger` out 1: to ball `bounce_trigger`.
- `bounce_direction` out 1: to ball `bounce_direction`. 0 = HORIZONTAL (flips vertical motion); 1 = VERTICAL (flips horizontal motion).
- `ball_reset_n` out 1: to ball active-LOW `reset`.
- `score_left`, `score_right` out 4 each: player scores.
- `game_over` out 1: high in GAME_OVER.

## Operation
- Internal motion model: `dir_left` and `dir_up`. Serve-side register `serve_right`, reset value 0.
- Collision arithmetic is 11-bit unsigned, so sums never wrap. Left paddle overlap: `ball_y+BALL_H > paddle_left_y` and `ball_y < paddle_left_y+PADDLE_H`. The right paddle uses the same test with `paddle_right_y`.
- FSM states:
  - IDLE: `ball_reset_n`=0. Goes to WAIT when `start`=1; on that transition the scores clear.
  - WAIT: `ball_reset_n`=1. Counts `SERVE_DELAY` ticks, then enters SERVE.
  - SERVE: `bounce_trigger`=1 and `bounce_direction`=`serve_right`. The ball's IDLE mapping turns HORIZONTAL into left-down and VERTICAL into right-down. Load `dir_left`=!`serve_right` and `dir_up`=0. Capture `ball_x`/`ball_y`, then enter HOLD.
  - PLAYING: evaluates collisions each tick, first match wins:
    1. Miss: `dir_left` and `ball_x <= MISS_L` → point to right player, go to POINT. Or `!dir_left` and `ball_x+BALL_W >= MISS_R` → point to left player, go to POINT.
    2. Paddle: `dir_left`, `ball_x <= PADDLE_LX+PADDLE_W`, and left overlap → VERTICAL bounce. The mirror case uses `ball_x+BALL_W >= PADDLE_RX` and right overlap.
    3. Wall: `dir_up` and `ball_y <= TOP_Y`, or `!dir_up` and `ball_y+BALL_H >= BOTTOM_Y` → HORIZONTAL bounce.
    
    A bounce sets `bounce_trigger`=1, drives `bounce_direction`, captures position and enters HOLD.
  - HOLD: keeps `bounce_trigger`=1 and `bounce_direction` stable until `ball_x` or `ball_y` differs from the captured value. The ball samples the trigger only on its speed divider. On exit, drop the trigger and return to PLAYING. If the exit follows a bounce, toggle `dir_left` (VERTICAL) or `dir_up` (HORIZONTAL); after a serve, toggle nothing.
  - POINT: increment the scorer's score. Set `serve_right` so the next serve goes toward the conceding player. Hold `ball_reset_n`=0 for `RESET_TICKS` ticks. Then go to GAME_OVER if the new score equals `WIN_SCORE`, else to WAIT.
  - GAME_OVER: `game_over`=1, `ball_reset_n`=0. Goes to WAIT when `start`=1; scores clear on that transition.
- Simultaneous paddle and wall contact: the paddle bounce is issued first. The wall is re-evaluated after HOLD exits, and is still caught because the contact conditions are inequalities.

## Timing
- `reset` asserted, asynchronously: state IDLE, `bounce_trigger`=0, `bounce_direction`=0, `ball_reset_n`=0, scores 0, `game_over`=0, counters 0, `dir_left`=0, `dir_up`=0.
- Outputs are registered. Collision detection to `bounce_trigger` high takes 1 tick.
- HOLD exits on the tick after the position change is seen. `bounce_trigger` then falls, so the trigger never spans a second ball move.
- POINT: the score updates on POINT entry. `ball_reset_n` is low for exactly `RESET_TICKS` ticks.
- WAIT → SERVE takes exactly `SERVE_DELAY` ticks after `ball_reset_n` rises.
- `reset` asserted mid-operation aborts everything. Scores clear and the ball is held in reset.

## Test plan
- Reset, then `start`=1 for 1 tick: `ball_reset_n` rises. After 60 ticks, `bounce_trigger`=1 with `bounce_direction`=0. Trigger stays high until `ball_x` changes and drops the next tick.
- Ball moving left-down at `ball_x`=30, `ball_y`=100, `paddle_left_y`=90: VERTICAL bounce. After the ball moves, `dir_left`=0 and `bounce_trigger`=0.
- Ball moving up at `ball_y`=0, `ball_x`=300: HORIZONTAL bounce. The trigger is held through 10 ticks of no motion and released 1 tick after `ball_y`=1.
- Ball moving left at `ball_x`=2, `paddle_left_y`=300: `score_right` 0→1, `ball_reset_n` low for 4 ticks, then WAIT, and the next serve has `bounce_direction`=0.
- `score_left`=8 and a right-side miss: `score_left`=9, then `game_over`=1. `start` clears the scores and releases the ball.
- `reset` pulsed while in HOLD: `bounce_trigger` drops immediately, state is IDLE, scores are 0.
